// File: rtl/ddr3_app_responder.sv
// DDR3 app_* interface responder: on-chip RAM model with calibration delay and fixed read latency.
// Optional backpressure: define DDR3_RESP_STALL_EN to throttle app_rdy/app_wdf_rdy with an LFSR.
//
// state    | meaning
// ST_CALIB | counting down calibration, ready outputs low, commands ignored
// ST_READY | calibration complete, commands accepted
module ddr3_app_responder #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LAT       = 4
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_rdy,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete,
  output logic                proto_err,
  output logic [31:0]         wr_cnt,
  output logic [31:0]         rd_cnt
);

  localparam int CALIB_W = $clog2(CALIB_CYCLES + 1);
  localparam int NBYTES  = DATA_W / 8;

  typedef enum logic {ST_CALIB, ST_READY} state_t;

  state_t               state_q;
  logic [CALIB_W-1:0]   calib_cnt_q;
  logic                 calib_done_q;
  logic                 ready_q;
  logic                 stall;

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CALIB;
      calib_cnt_q  <= CALIB_W'(CALIB_CYCLES - 1);
      calib_done_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_CALIB: begin
          if (calib_cnt_q == '0) begin
            state_q      <= ST_READY;
            calib_done_q <= 1'b1;
            ready_q      <= 1'b1;
          end else begin
            calib_cnt_q <= calib_cnt_q - 1'b1;
          end
        end
        ST_READY: state_q <= ST_READY;
        default: begin
          state_q      <= ST_CALIB;
          calib_done_q <= 1'b0;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DDR3_RESP_STALL_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; only steps once calibration is done.
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (ready_q) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[2:0] == 3'd0);
`else
  assign stall = 1'b0;
`endif

  assign app_rdy     = ready_q & ~stall;
  assign app_wdf_rdy = ready_q & ~stall;

  logic [MEM_AW-1:0] idx;
  logic              cmd_wr, wr_acc, rd_acc, bad;
  logic              unused_addr_bits;

  assign idx              = app_addr[MEM_AW+2:3];
  assign unused_addr_bits = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0]};

  assign cmd_wr = app_en & app_rdy & (app_cmd == 3'd0);
  assign wr_acc = cmd_wr & app_wdf_wren & app_wdf_rdy;
  assign rd_acc = app_en & app_rdy & (app_cmd == 3'd1);

  // A data beat counts as orphaned only when it could have been accepted.
  assign bad = ready_q & ((app_en & (app_cmd > 3'd1))
                        | (cmd_wr & ~app_wdf_wren)
                        | (app_wdf_wren & app_wdf_rdy & ~cmd_wr)
                        | (app_wdf_end != app_wdf_wren));

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] ram_dout_q;

  always_ff @(posedge ui_clk) begin
    if (wr_acc) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!app_wdf_mask[b]) mem[idx][b*8 +: 8] <= app_wdf_data[b*8 +: 8];
      end
    end
    if (rd_acc) ram_dout_q <= mem[idx];
  end

  // vld_q[0] tags the RAM output register; vld_q[RD_LAT-1] is the outgoing valid.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] pipe_q [1:RD_LAT-1];
  logic [DATA_W-1:0] pipe_d [1:RD_LAT-1];
  logic [31:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              proto_err_q, proto_err_d;

  always_comb begin
    vld_d = {vld_q[RD_LAT-2:0], rd_acc};
    pipe_d = pipe_q;
    pipe_d[1] = ram_dout_q;
    for (int k = 2; k < RD_LAT; k++) pipe_d[k] = pipe_q[k-1];
    // Output stage keeps the last burst while no new data arrives.
    if (!vld_q[RD_LAT-2]) pipe_d[RD_LAT-1] = pipe_q[RD_LAT-1];
    wr_cnt_d    = wr_cnt_q + 32'(wr_acc);
    rd_cnt_d    = rd_cnt_q + 32'(rd_acc);
    proto_err_d = proto_err_q | bad;
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_d[k];
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign app_rd_data         = pipe_q[RD_LAT-1];
  assign app_rd_data_valid   = vld_q[RD_LAT-1];
  assign app_rd_data_end     = vld_q[RD_LAT-1];
  assign init_calib_complete = calib_done_q;
  assign proto_err           = proto_err_q;
  assign wr_cnt              = wr_cnt_q;
  assign rd_cnt              = rd_cnt_q;

endmodule
